bcd_scan_counter: RTL and testbench

//  Multi-digit BCD up/down counter with time-multiplexed digit scan.

---
 rtl/bcd_scan_counter.sv | 190 +++++++++++++++++++
 tb/tb_bcd_scan_counter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_counter.sv
// -----------------------------------------------------------------------------
// bcd_scan_counter
//
// Multi-digit BCD up/down counter with a time-multiplexed digit scan. It feeds
// a single BCD-to-7-segment decoder. One digit is presented at a time on bcd,
// and a one-hot dig_sel tells the display which digit position is active.
//
// Parameters
//   DIGITS    number of BCD digits (>= 2)
//   SCAN_DIV  clk cycles each digit stays selected (>= 2)
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous, active-high reset
//   en        in   count enable, one step per clk while high
//   up        in   direction: 1 = increment, 0 = decrement
//   load      in   synchronous load of load_val (wins over en)
//   load_val  in   BCD value to load; digit 0 in bits [3:0]; nibbles >9 load as 0
//   value     out  current counter value, registered
//   ovf       out  one-cycle pulse after a wrap in either direction
//   bcd       out  selected digit {A,B,C,D}, to the decoder
//   dig_sel   out  one-hot digit select, bit i = digit i active
//   blank     out  1 = selected digit is a leading zero (digit 0 never blanked)
// -----------------------------------------------------------------------------
module bcd_scan_counter #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   value,
    output logic                  ovf,
    output logic [3:0]            bcd,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  blank
);

    localparam int IW = $clog2(DIGITS);
    localparam int PW = $clog2(SCAN_DIV);

    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

    // Counter state
    logic [4*DIGITS-1:0] r_value;
    logic                r_ovf;

    // Scan state
    logic [PW-1:0]       r_presc;
    logic [IW-1:0]       r_idx;

    // Output registers
    logic [3:0]          r_bcd;
    logic [DIGITS-1:0]   r_sel;
    logic                r_blank;

    // Next-state candidates
    logic [4*DIGITS-1:0] w_inc;
    logic [4*DIGITS-1:0] w_dec;
    logic [4*DIGITS-1:0] w_load_clean;
    logic                w_inc_wrap;
    logic                w_dec_wrap;

    logic                w_presc_tc;
    logic [IW-1:0]       w_idx_next;
    logic [3:0]          w_digit_next;
    logic                w_blank_next;
    logic [DIGITS-1:0]   w_sel_next;

    // -------------------------------------------------------------------------
    // BCD increment / decrement with digit-by-digit ripple. A carry (borrow)
    // that falls out of the top digit means every digit was 9 (0): a wrap.
    // -------------------------------------------------------------------------
    always_comb begin : inc_dec
        logic carry;
        logic borrow;
        // NOTE: every variable gets a default before any conditional update,
        // so no path leaves it unassigned and no latch is inferred.
        carry  = 1'b1;
        borrow = 1'b1;
        w_inc  = r_value;
        w_dec  = r_value;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (r_value[4*i +: 4] == 4'd9) begin
                    w_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_inc[4*i +: 4] = r_value[4*i +: 4] + 4'd1;
                    carry           = 1'b0;
                end
            end
            if (borrow) begin
                if (r_value[4*i +: 4] == 4'd0) begin
                    w_dec[4*i +: 4] = 4'd9;
                end else begin
                    w_dec[4*i +: 4] = r_value[4*i +: 4] - 4'd1;
                    borrow          = 1'b0;
                end
            end
        end
        w_inc_wrap = carry;
        w_dec_wrap = borrow;
    end

    // Illegal nibbles are forced to 0 so value never holds a non-BCD digit.
    always_comb begin : load_sanitize
        w_load_clean = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] <= 4'd9) begin
                w_load_clean[4*i +: 4] = load_val[4*i +: 4];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Scan: the output registers are loaded from the index the scan will hold
    // after this edge, so dig_sel lines up with the scan index and bcd/dig_sel
    // always come from the same index.
    // -------------------------------------------------------------------------
    assign w_presc_tc = (r_presc == PRESC_MAX);
    assign w_idx_next = !w_presc_tc        ? r_idx :
                        (r_idx == IDX_MAX) ? '0    :
                                             r_idx + IW'(1);
    assign w_sel_next = DIGITS'(1) << w_idx_next;

    // Walk from the top digit down so all_zero covers digit i and everything
    // above it, which is exactly the leading-zero condition.
    always_comb begin : digit_mux
        logic all_zero;
        all_zero     = 1'b1;
        w_digit_next = 4'd0;
        w_blank_next = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero && (r_value[4*i +: 4] == 4'd0);
            if (w_idx_next == IW'(i)) begin
                w_digit_next = r_value[4*i +: 4];
                w_blank_next = (i != 0) && all_zero;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= '0;
            r_ovf   <= 1'b0;
            r_presc <= '0;
            r_idx   <= '0;
            r_bcd   <= 4'd0;
            r_sel   <= DIGITS'(1);
            r_blank <= 1'b0;
        end else begin
            if (load) begin
                r_value <= w_load_clean;
                r_ovf   <= 1'b0;
            end else if (en) begin
                if (up) begin
                    r_value <= w_inc;
                    r_ovf   <= w_inc_wrap;
                end else begin
                    r_value <= w_dec;
                    r_ovf   <= w_dec_wrap;
                end
            end else begin
                r_ovf <= 1'b0;
            end

            r_presc <= w_presc_tc ? '0 : r_presc + PW'(1);
            r_idx   <= w_idx_next;
            r_bcd   <= w_digit_next;
            r_sel   <= w_sel_next;
            r_blank <= w_blank_next;
        end
    end

    assign value   = r_value;
    assign ovf     = r_ovf;
    assign bcd     = r_bcd;
    assign dig_sel = r_sel;
    assign blank   = r_blank;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_scan_counter
//
// Scoreboarded bench for bcd_scan_counter (DIGITS=4, SCAN_DIV=4). The driver
// applies inputs on the falling edge, advances an integer reference model
// (value kept as a plain number modulo 10^DIGITS, scan position derived from
// cycles since reset) and queues the expected post-edge outputs. A monitor
// pops one entry after every rising edge and compares all outputs.
// -----------------------------------------------------------------------------
module tb_bcd_scan_counter;

    localparam int D    = 4;
    localparam int SD   = 4;
    localparam int W    = 4 * D;
    localparam int NMOD = 10000;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] value;
    logic         ovf;
    logic [3:0]   bcd;
    logic [D-1:0] dig_sel;
    logic         blank;

    bcd_scan_counter #(.DIGITS(D), .SCAN_DIV(SD)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .value    (value),
        .ovf      (ovf),
        .bcd      (bcd),
        .dig_sel  (dig_sel),
        .blank    (blank)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] value;
        logic         ovf;
        logic [3:0]   bcd;
        logic [D-1:0] sel;
        logic         blank;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_val  = 0;   // counter value as an ordinary integer
    int   m_cyc  = 0;   // rising edges since reset was released

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic int pow10(input int e);
        int r = 1;
        for (int k = 0; k < e; k++) r = r * 10;
        return r;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r = '0;
        for (int k = 0; k < D; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
        return r;
    endfunction

    // Drive one cycle's inputs, predict the result of the coming rising edge,
    // then wait for the following falling edge.
    task automatic step(input logic ld, input logic [W-1:0] lv, input logic e, input logic u);
        exp_t x;
        int   idx;
        int   nxt;
        load     = ld;
        load_val = lv;
        en       = e;
        up       = u;

        // Display outputs reflect the pre-edge value at the post-edge position.
        idx     = ((m_cyc + 1) / SD) % D;
        x.bcd   = 4'((m_val / pow10(idx)) % 10);
        x.sel   = D'(1) << idx;
        x.blank = (idx > 0) && (m_val / pow10(idx) == 0);
        x.ovf   = 1'b0;

        if (ld) begin
            nxt = 0;
            for (int k = 0; k < D; k++) begin
                if (int'(lv[4*k +: 4]) <= 9) nxt += int'(lv[4*k +: 4]) * pow10(k);
            end
        end else if (e && u) begin
            x.ovf = (m_val == NMOD - 1);
            nxt   = (m_val + 1) % NMOD;
        end else if (e) begin
            x.ovf = (m_val == 0);
            nxt   = (m_val + NMOD - 1) % NMOD;
        end else begin
            nxt = m_val;
        end

        x.value = to_bcd(nxt);
        m_val   = nxt;
        m_cyc++;
        q.push_back(x);
        @(negedge clk);
    endtask

    // Called shortly after a falling edge: reset asynchronously, away from any
    // clock edge, and confirm the outputs clear before the next edge.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        q.delete();
        #1;
        check("rst_value", 32'(value), 32'h0);
        check("rst_sel", 32'(dig_sel), 32'h1);
        check("rst_bcd", 32'(bcd), 32'h0);
        check("rst_ovf", 32'(ovf), 32'h0);
        check("rst_blank", 32'(blank), 32'h0);
        @(negedge clk);
        rst   = 1'b0;
        m_val = 0;
        m_cyc = 0;
    endtask

    // Monitor: one expectation per rising edge outside reset.
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (!rst && q.size() > 0) begin
            x = q.pop_front();
            check("value", 32'(value), 32'(x.value));
            check("ovf", 32'(ovf), 32'(x.ovf));
            check("bcd", 32'(bcd), 32'(x.bcd));
            check("dig_sel", 32'(dig_sel), 32'(x.sel));
            check("blank", 32'(blank), 32'(x.blank));
        end
    end

    initial begin
        int ovf_count;
        logic [W-1:0] lv;

        rst      = 1'b1;
        en       = 1'b0;
        up       = 1'b0;
        load     = 1'b0;
        load_val = '0;
        @(negedge clk);
        check("init_value", 32'(value), 32'h0);
        check("init_sel", 32'(dig_sel), 32'h1);
        rst = 1'b0;

        // Reset in the middle of counting
        step(1'b1, 16'h0123, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b0, '0, 1'b1, 1'b1);
        do_reset();

        // Up wrap from 9998
        step(1'b1, 16'h9998, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        check("up_9999", 32'(value), 32'h9999);
        check("up_9999_ovf", 32'(ovf), 32'h0);
        step(1'b0, '0, 1'b1, 1'b1);
        check("up_wrap", 32'(value), 32'h0000);
        check("up_wrap_ovf", 32'(ovf), 32'h1);
        step(1'b0, '0, 1'b0, 1'b1);
        check("up_ovf_clear", 32'(ovf), 32'h0);

        // Down wrap and down borrow
        step(1'b1, 16'h0000, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("dn_wrap", 32'(value), 32'h9999);
        check("dn_wrap_ovf", 32'(ovf), 32'h1);
        step(1'b1, 16'h0100, 1'b0, 1'b0);
        check("load_ovf_clear", 32'(ovf), 32'h0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("dn_borrow", 32'(value), 32'h0099);

        // Load beats enable, illegal nibbles become 0
        step(1'b1, 16'hA3F7, 1'b1, 1'b1);
        check("load_clean", 32'(value), 32'h0307);

        // Hold 0042 across a full scan rotation
        step(1'b1, 16'h0042, 1'b0, 1'b0);
        for (int k = 0; k < 4 * SD * D; k++) step(1'b0, '0, 1'b0, $urandom_range(0, 1) == 1);

        // Full rotation up from 0000: exactly one wrap
        step(1'b1, 16'h0000, 1'b0, 1'b0);
        ovf_count = 0;
        for (int k = 0; k < NMOD; k++) begin
            step(1'b0, '0, 1'b1, 1'b1);
            if (ovf) ovf_count++;
        end
        check("full_value", 32'(value), 32'h0000);
        check("full_ovf_count", 32'(ovf_count), 32'd1);

        // Randomized traffic with occasional mid-run resets
        for (int k = 0; k < 4000; k++) begin
            case ($urandom_range(0, 3))
                0:       lv = 16'($urandom);
                1:       lv = ($urandom_range(0, 1) == 1) ? to_bcd(9990 + $urandom_range(0, 9))
                                                          : to_bcd($urandom_range(0, 9));
                default: lv = to_bcd($urandom_range(0, NMOD - 1));
            endcase
            step($urandom_range(0, 15) == 0, lv, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 999) == 0) do_reset();
        end

        step(1'b0, '0, 1'b0, 1'b0);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
